aes_inv_round_seq: RTL and testbench
====================================

AES_INV_ROUND_SEQ -- requirements
Module: aes_inv_round_seq

Interface
REQ-001 Parameter: NR, default 10, number of AES rounds; only 10 (AES-128) is supported.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: key_valid  input  1  round-key store holds a complete, stable expanded key.
REQ-005 Port: in_valid  input  1  ciphertext block offered.
REQ-006 Port: in_ready  output  1  block accepted when in_valid && in_ready.
REQ-007 Port: in_data  input  128  ciphertext block, byte 0 at [127:120].
REQ-008 Port: rk_idx  output  4  round-key index presented to the external key store.
REQ-009 Port: rk_data  input  128  round key for rk_idx, combinational from the key store, same cycle.
REQ-010 Port: out_valid  output  1  plaintext block available.
REQ-011 Port: out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-012 Port: out_data  output  128  plaintext block.
REQ-013 Port: busy  output  1  high in any state other than IDLE.
REQ-014 Port: blk_count  output  32  count of blocks delivered on the output handshake.

Function
REQ-015 The block shall instantiate one inverse-round datapath (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns) and one final-round datapath (no InvMixColumns), and reuse them iteratively, one round per cycle.
REQ-016 FSM states: IDLE, ROUND, FINAL, DONE; 128-bit state register; 4-bit round counter.
REQ-017 IDLE: in_ready = key_valid; rk_idx = NR (10); on accept, state_reg <= in_data XOR rk_data, cnt <= 9, next state ROUND.
REQ-018 ROUND: rk_idx = cnt; state_reg <= inverse-round(state_reg, rk_data); if cnt == 1, go to FINAL; otherwise cnt <= cnt - 1.
REQ-019 FINAL: rk_idx = 0; state_reg <= final-round(state_reg, rk_data); out_valid <= 1; go to DONE.
REQ-020 DONE: out_valid = 1; out_data = state_reg, held stable; on out_ready, out_valid <= 0, blk_count <= blk_count + 1, go to IDLE.
REQ-021 Latency: accept at edge T gives out_valid high in the cycle following edge T+10 (11 clocks: 1 initial AddRoundKey, 9 rounds, 1 final).
REQ-022 in_ready shall be 0 in ROUND, FINAL and DONE; at most one block is in flight; no input buffering.
REQ-023 Back-to-back: a new block is accepted no earlier than the cycle after the output handshake, because in_ready is 0 in DONE.
REQ-024 out_ready held low in DONE: out_data and out_valid are held indefinitely and nothing else changes.
REQ-025 key_valid deasserted after accept: the operation completes using whatever rk_data presents; the key store owner must not change keys while busy = 1.
REQ-026 rk_idx in DONE = 0; no X on rk_idx in any state.
REQ-027 blk_count wraps 0xFFFFFFFF -> 0.
REQ-028 in_valid while not in IDLE is ignored; in_data is sampled only on the accept edge.

Reset
REQ-029 With rst = 1 at an edge: state <= IDLE, cnt <= 0, state_reg <= 0, out_valid <= 0, blk_count <= 0; out_data = 0, busy = 0.
REQ-030 Reset mid-operation (ROUND, FINAL, DONE) abandons the block with no output handshake; in_ready = key_valid from the next cycle.
REQ-031 rst takes priority over every handshake in the same cycle.

Verification
REQ-032 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, in_data 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff, out_valid exactly 11 cycles after accept, rk_idx sequence 10,9,...,1,0.
REQ-033 Backpressure: hold out_ready = 0 for 20 cycles -> out_data stable, in_ready = 0, blk_count unchanged; then a 1-cycle out_ready -> blk_count increments by 1 and FSM returns to IDLE.
REQ-034 Back-to-back: two blocks with in_valid held high and out_ready = 1 -> second accept occurs on the cycle after the first output handshake; both results correct.
REQ-035 Reset at cycle 5 after accept -> busy = 0 and out_valid = 0 next cycle, no output; a following block decrypts correctly.
REQ-036 key_valid = 0 with in_valid = 1 -> in_ready = 0, no accept, busy = 0; key_valid rises -> accept in that cycle.
REQ-037 Preload blk_count to 0xFFFFFFFF via force, complete one block -> blk_count = 0.

Source files
------------

// File: rtl/aes_inv_round_seq.sv
// ---------------------------------------------------------------------------
// aes_inv_round_seq
// Iterative AES-128 decryption core. One ciphertext block is taken in at a
// time. The core uses one inverse-round datapath and does one round per
// clock. Round keys are fetched from an external key store: rk_idx is
// presented and rk_data comes back combinationally in the same cycle.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   rst        : synchronous, active-high reset (wins over every handshake)
//   key_valid  : the key store holds a complete, stable expanded key
//   in_valid   : ciphertext block offered
//   in_ready   : block accepted when in_valid && in_ready (IDLE only)
//   in_data    : ciphertext, byte 0 at [127:120]
//   rk_idx     : round-key index driven to the key store
//   rk_data    : round key for rk_idx (same-cycle, combinational)
//   out_valid  : plaintext available, held until out_ready
//   out_ready  : downstream accepts when out_valid && out_ready
//   out_data   : plaintext block
//   busy       : high in any state other than IDLE
//   blk_count  : number of blocks delivered on the output handshake (wraps)
//
// NR is the round count. Only 10 (AES-128) is supported.
// ---------------------------------------------------------------------------
module aes_inv_round_seq #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [31:0]  blk_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t       state_r;
  logic [3:0]   cnt_r;
  logic [127:0] state_reg_r;
  logic         out_valid_r;
  logic [31:0]  blk_count_r;

  logic [127:0] sub_shift_s;
  logic [127:0] final_round_s;
  logic [127:0] inv_round_s;

  // ---------------------------------------------------------------------
  // GF(2^8) helpers (reduction polynomial x^8 + x^4 + x^3 + x + 1)
  // ---------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      else      p = p;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254. Square-and-multiply gives a^127, and
  // one more square gives a^254. An input of 0 maps to 0, which is what
  // the S-box needs.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) begin
      r = gmul(gmul(r, r), a);
    end
    return gmul(r, r);
  endfunction

  // Inverse S-box: undo the affine transform, then invert in GF(2^8).
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] a;
    a = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return ginv(a);
  endfunction

  // InvShiftRows followed by InvSubBytes. Byte index = row + 4*column,
  // and row r is rotated right by r positions.
  function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
    logic [127:0] res;
    int src;
    int dst;
    res = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = r + 4 * c;
        dst = r + 4 * ((c + r) % 4);
        res[127 - 8 * dst -: 8] = inv_sbox(s[127 - 8 * src -: 8]);
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] res;
    logic [7:0]   a0;
    logic [7:0]   a1;
    logic [7:0]   a2;
    logic [7:0]   a3;
    res = 128'd0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      res[127 - 32 * c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      res[119 - 32 * c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      res[111 - 32 * c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      res[103 - 32 * c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return res;
  endfunction

  // Round datapaths. The final round is the inverse round without
  // InvMixColumns, so both rounds share the shift/sub/add front end.
  always_comb begin
    sub_shift_s   = inv_sub_shift(state_reg_r);
    final_round_s = sub_shift_s ^ rk_data;
    inv_round_s   = inv_mix_columns(final_round_s);
  end

  // Decode of the handshake and key-index outputs from the FSM state
  always_comb begin
    in_ready = 1'b0;
    rk_idx   = 4'd0;
    case (state_r)
      IDLE: begin
        in_ready = key_valid;
        rk_idx   = 4'(NR);
      end
      ROUND: begin
        in_ready = 1'b0;
        rk_idx   = cnt_r;
      end
      FINAL: begin
        in_ready = 1'b0;
        rk_idx   = 4'd0;
      end
      DONE: begin
        in_ready = 1'b0;
        rk_idx   = 4'd0;
      end
      default: begin
        in_ready = 1'b0;
        rk_idx   = 4'd0;
      end
    endcase
  end

  assign busy      = (state_r != IDLE);
  assign out_valid = out_valid_r;
  assign out_data  = state_reg_r;
  assign blk_count = blk_count_r;

  // Control FSM, state register, round counter and delivered-block counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      state_reg_r <= 128'd0;
      out_valid_r <= 1'b0;
      blk_count_r <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && key_valid) begin
            // The initial AddRoundKey uses the last round key (rk_idx = NR).
            state_reg_r <= in_data ^ rk_data;
            cnt_r       <= 4'(NR - 1);
            state_r     <= ROUND;
          end
        end
        ROUND: begin
          state_reg_r <= inv_round_s;
          if (cnt_r == 4'd1) begin
            state_r <= FINAL;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        FINAL: begin
          state_reg_r <= final_round_s;
          out_valid_r <= 1'b1;
          state_r     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            blk_count_r <= blk_count_r + 32'd1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_round_seq.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_round_seq
// Directed and randomized bench for the iterative AES-128 decryptor. The
// reference side is a forward AES-128 encryptor with its own key schedule
// and S-box generator. Random plaintexts are encrypted here, the DUT
// decrypts them, and the DUT result must equal the original plaintext.
// The expanded key also serves as the combinational round-key store.
// ---------------------------------------------------------------------------
module tb_aes_inv_round_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic [31:0]  blk_count;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [31:0]  exp_cnt;
  logic [7:0]   sbox [256];
  logic [127:0] rk_mem [16];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

  always #5 clk = ~clk;

  assign rk_data = rk_mem[rk_idx];

  aes_inv_round_seq #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .blk_count (blk_count)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = (v << n) | (v >> (8 - n));
    return r;
  endfunction

  function automatic logic [7:0] mul2(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward S-box: walk p over powers of 3 and q over powers of 1/3.
  task automatic build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  task automatic key_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h000000};
        rc = mul2(rc);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= 10) rk_mem[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
      else         rk_mem[r] = 128'd0;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ rk_mem[0][127 - 8 * i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r + 4 * c] = sbox[s[r + 4 * ((c + r) % 4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4 * c]; a1 = t[4 * c + 1]; a2 = t[4 * c + 2]; a3 = t[4 * c + 3];
        if (rnd != 10) begin
          s[4 * c]     = mul2(a0) ^ mul2(a1) ^ a1 ^ a2 ^ a3;
          s[4 * c + 1] = a0 ^ mul2(a1) ^ mul2(a2) ^ a2 ^ a3;
          s[4 * c + 2] = a0 ^ a1 ^ mul2(a2) ^ mul2(a3) ^ a3;
          s[4 * c + 3] = mul2(a0) ^ a0 ^ a1 ^ a2 ^ mul2(a3);
        end else begin
          s[4 * c] = a0; s[4 * c + 1] = a1; s[4 * c + 2] = a2; s[4 * c + 3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_mem[rnd][127 - 8 * i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- bench helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Counts cycles from the accept edge until out_valid, bounded at 30.
  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_full(input string tag, input logic [127:0] ct,
                          input logic [127:0] pt, input bit drop_key);
    int lat;
    key_valid = 1'b1;
    in_data   = ct;
    in_valid  = 1'b1;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    if (drop_key) key_valid = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    wait_out(lat);
    chk({tag, "_latency"}, lat, 10);
    chk({tag, "_data"}, out_data, pt);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt   = exp_cnt + 32'd1;
    chk({tag, "_count"}, blk_count, exp_cnt);
    chk({tag, "_valid_low"}, out_valid, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pt;
    logic [127:0] pt2;
    logic [127:0] ct;
    logic [127:0] ct2;
    logic         seen;
    int           lat;

    build_sbox();
    key_expand(C1_KEY);

    // Reset state
    rst = 1'b1; key_valid = 1'b0; in_valid = 1'b0; in_data = 128'd0; out_ready = 1'b0;
    exp_cnt = 32'd0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_busy", busy, 0);
    chk("rst_blk_count", blk_count, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;

    // No key: offered block is not taken
    in_valid = 1'b1; in_data = C1_CT;
    tick(); tick();
    chk("nokey_in_ready", in_ready, 0);
    chk("nokey_busy", busy, 0);
    key_valid = 1'b1;
    #1;
    chk("key_in_ready", in_ready, 1);
    chk("idle_rk_idx", rk_idx, 10);
    tick();
    in_valid = 1'b0;
    chk("c1_busy", busy, 1);

    // FIPS-197 C.1 with round-key index walk and exact latency
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("c1_rk_idx_%0d", k), rk_idx, 10 - k);
      chk($sformatf("c1_no_valid_%0d", k), out_valid, 0);
      chk($sformatf("c1_no_ready_%0d", k), in_ready, 0);
      tick();
    end
    chk("c1_out_valid", out_valid, 1);
    chk("c1_out_data", out_data, C1_PT);
    chk("c1_done_rk_idx", rk_idx, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt = 32'd1;
    chk("c1_count", blk_count, exp_cnt);
    chk("c1_idle", busy, 0);

    // Random key, random blocks. Block 2 drops key_valid mid-operation.
    key_expand(rnd128());
    for (int b = 0; b < 4; b++) begin
      pt = rnd128();
      run_full($sformatf("rnd%0d", b), aes_enc(pt), pt, b == 2);
    end

    // Backpressure for 20 cycles with in_valid asserted (must be ignored)
    pt = rnd128(); ct = aes_enc(pt);
    key_valid = 1'b1; in_valid = 1'b1; in_data = ct;
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    chk("bp_latency", lat, 10);
    in_valid = 1'b1; in_data = rnd128();
    for (int k = 0; k < 20; k++) begin
      chk("bp_data", out_data, pt);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_count", blk_count, exp_cnt);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; exp_cnt = exp_cnt + 32'd1;
    chk("bp_count_inc", blk_count, exp_cnt);
    chk("bp_idle", busy, 0);
    chk("bp_in_ready_back", in_ready, 1);

    // Back-to-back with in_valid held and out_ready high
    pt = rnd128(); ct = aes_enc(pt);
    pt2 = rnd128(); ct2 = aes_enc(pt2);
    out_ready = 1'b1; in_valid = 1'b1; in_data = ct;
    tick();
    in_data = ct2;
    wait_out(lat);
    chk("b2b_lat1", lat, 10);
    chk("b2b_data1", out_data, pt);
    tick();
    exp_cnt = exp_cnt + 32'd1;
    chk("b2b_count1", blk_count, exp_cnt);
    chk("b2b_gap_idle", busy, 0);
    chk("b2b_gap_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("b2b_second_accept", busy, 1);
    wait_out(lat);
    chk("b2b_lat2", lat, 10);
    chk("b2b_data2", out_data, pt2);
    tick();
    out_ready = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    chk("b2b_count2", blk_count, exp_cnt);
    chk("b2b_idle", busy, 0);

    // Reset 5 cycles after accept, with in_valid high during reset
    pt = rnd128(); ct = aes_enc(pt);
    in_valid = 1'b1; in_data = ct;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    exp_cnt = 32'd0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 128'd0);
    chk("mid_rst_count", blk_count, exp_cnt);
    chk("mid_rst_in_ready", in_ready, 1);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    chk("mid_rst_no_output", seen, 0);
    pt = rnd128();
    run_full("post_rst", aes_enc(pt), pt, 1'b0);

    // Reset wins over an output handshake in the same cycle
    pt = rnd128(); ct = aes_enc(pt);
    in_valid = 1'b1; in_data = ct;
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    chk("rstprio_lat", lat, 10);
    out_ready = 1'b1; rst = 1'b1;
    tick();
    out_ready = 1'b0; rst = 1'b0;
    exp_cnt = 32'd0;
    chk("rstprio_count", blk_count, exp_cnt);
    chk("rstprio_valid", out_valid, 0);
    chk("rstprio_busy", busy, 0);

    // Counter wrap
    force dut.blk_count_r = 32'hFFFF_FFFF;
    tick();
    release dut.blk_count_r;
    exp_cnt = 32'hFFFF_FFFF;
    chk("wrap_preload", blk_count, exp_cnt);
    pt = rnd128();
    run_full("wrap", aes_enc(pt), pt, 1'b0);
    chk("wrap_zero", blk_count, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
